// File: rtl/ysyx_23060240_axi_sram_pkg.sv
// Shared types for the AXI4-Lite SRAM slave: response codes and the
// read/write channel state encodings.
package ysyx_23060240_axi_sram_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_DATA
    } r_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT,
        W_RESP
    } w_state_e;

endpackage

// File: rtl/ysyx_23060240_lfsr8.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), free-running, used as the
// source of random response delays.
module ysyx_23060240_lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= SEED;
        end else begin
            q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
        end
    end

endmodule

// File: rtl/ysyx_23060240_axi_sram.sv
// AXI4-Lite word-addressed SRAM slave with independent read and write FSMs
// and fixed or LFSR-random response latency; out-of-window accesses get DECERR.
//
// Handshakes: a transfer happens on the rising clk edge where valid and ready
// are both high; a valid, once raised by this slave, holds with a stable
// payload until that edge.
module ysyx_23060240_axi_sram
    import ysyx_23060240_axi_sram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          RD_LAT      = 1,
    parameter int          WR_LAT      = 1,
    parameter bit          RAND_LAT    = 1'b0,
    parameter int          LAT_BITS    = 3,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int          IDX_W   = $clog2(DEPTH_WORDS);
    localparam int          CNT_W   = 8;
    localparam logic [32:0] WIN_END = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);

    logic [31:0] mem [DEPTH_WORDS];

    logic [7:0] lfsr_q;

    ysyx_23060240_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    logic [CNT_W-1:0] rd_delay, wr_delay;
    assign rd_delay = RAND_LAT ? CNT_W'(lfsr_q[LAT_BITS-1:0]) : CNT_W'(RD_LAT);
    assign wr_delay = RAND_LAT ? CNT_W'(lfsr_q[2*LAT_BITS-1:LAT_BITS]) : CNT_W'(WR_LAT);

    // Window check done in 33 bits so a window ending at 4 GiB still decodes.
    logic [31:0] ar_off, aw_off;
    logic        ar_in, aw_in;
    assign ar_off = araddr - BASE_ADDR;
    assign aw_off = awaddr - BASE_ADDR;
    assign ar_in  = ({1'b0, araddr} >= {1'b0, BASE_ADDR}) && ({1'b0, araddr} < WIN_END);
    assign aw_in  = ({1'b0, awaddr} >= {1'b0, BASE_ADDR}) && ({1'b0, awaddr} < WIN_END);

    logic unused_bits;
    assign unused_bits = ^{lfsr_q, ar_off, aw_off};

    // ---------------- read channel ----------------
    r_state_e         r_state, r_state_n;
    logic [CNT_W-1:0] rcnt;
    logic [IDX_W-1:0] r_idx;
    logic             r_ok;
    logic             r_load, r_fire;

    assign arready = (r_state == R_IDLE);
    assign rvalid  = (r_state == R_DATA);

    always_comb begin
        r_state_n = r_state;
        r_load    = 1'b0;
        r_fire    = 1'b0;
        unique case (r_state)
            R_IDLE: if (arvalid) begin
                r_state_n = R_WAIT;
                r_load    = 1'b1;
            end
            R_WAIT: if (rcnt == '0) begin
                r_state_n = R_DATA;
                r_fire    = 1'b1;
            end
            R_DATA: if (rready) r_state_n = R_IDLE;
            default: r_state_n = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            rcnt    <= '0;
            r_idx   <= '0;
            r_ok    <= 1'b0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
        end else begin
            r_state <= r_state_n;
            if (r_load) begin
                r_idx <= ar_off[IDX_W+1:2];
                r_ok  <= ar_in;
                rcnt  <= rd_delay;
            end else if (r_state == R_WAIT && rcnt != '0) begin
                rcnt <= rcnt - 1'b1;
            end
            // Same-edge write commit lands after this sample: reads see old data.
            if (r_fire) begin
                rdata <= r_ok ? mem[r_idx] : 32'h0;
                rresp <= r_ok ? RESP_OKAY : RESP_DECERR;
            end
        end
    end

    // ---------------- write channel ----------------
    w_state_e         w_state, w_state_n;
    logic [CNT_W-1:0] wcnt;
    logic [IDX_W-1:0] w_idx;
    logic             w_ok;
    logic [31:0]      w_data;
    logic [3:0]       w_strb;
    logic             aw_held, w_held;
    logic             aw_hs, w_hs;
    logic             w_load, w_commit;

    assign awready = (w_state == W_IDLE) && !aw_held;
    assign wready  = (w_state == W_IDLE) && !w_held;
    assign bvalid  = (w_state == W_RESP);
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;

    always_comb begin
        w_state_n = w_state;
        w_load    = 1'b0;
        w_commit  = 1'b0;
        unique case (w_state)
            W_IDLE: if ((aw_held || aw_hs) && (w_held || w_hs)) begin
                w_state_n = W_WAIT;
                w_load    = 1'b1;
            end
            W_WAIT: if (wcnt == '0) begin
                w_state_n = W_RESP;
                w_commit  = 1'b1;
            end
            W_RESP: if (bready) w_state_n = W_IDLE;
            default: w_state_n = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
            wcnt    <= '0;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            w_idx   <= '0;
            w_ok    <= 1'b0;
            w_data  <= '0;
            w_strb  <= '0;
            bresp   <= RESP_OKAY;
        end else begin
            w_state <= w_state_n;
            if (aw_hs) begin
                w_idx <= aw_off[IDX_W+1:2];
                w_ok  <= aw_in;
            end
            if (w_hs) begin
                w_data <= wdata;
                w_strb <= wstrb;
            end
            if (w_load) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                wcnt    <= wr_delay;
            end else begin
                if (aw_hs) aw_held <= 1'b1;
                if (w_hs)  w_held  <= 1'b1;
                if (w_state == W_WAIT && wcnt != '0) wcnt <= wcnt - 1'b1;
            end
            if (w_commit) bresp <= w_ok ? RESP_OKAY : RESP_DECERR;
        end
    end

    // RAM array is deliberately not reset; a reset on the commit edge cancels the write.
    always_ff @(posedge clk) begin
        if (w_commit && w_ok && !rst) begin
            for (int b = 0; b < 4; b++) begin
                if (w_strb[b]) mem[w_idx][8*b +: 8] <= w_data[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060240_axi_sram.sv
// Scoreboard bench for the AXI4-Lite SRAM: a fixed-latency instance (index 0)
// for timing/directed cases and an LFSR-latency instance (index 1) for random traffic.
module tb_ysyx_23060240_axi_sram;
    import ysyx_23060240_axi_sram_pkg::*;

    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam int          DEPTH  = 4096;
    localparam int          FIX_RD = 0;
    localparam int          FIX_WR = 2;
    localparam int          TMO    = 200;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] araddr  [2];
    logic        arvalid [2];
    logic        arready [2];
    logic [31:0] rdata   [2];
    logic [1:0]  rresp   [2];
    logic        rvalid  [2];
    logic        rready  [2];
    logic [31:0] awaddr  [2];
    logic        awvalid [2];
    logic        awready [2];
    logic [31:0] wdata   [2];
    logic [3:0]  wstrb   [2];
    logic        wvalid  [2];
    logic        wready  [2];
    logic [1:0]  bresp   [2];
    logic        bvalid  [2];
    logic        bready  [2];

    ysyx_23060240_axi_sram #(
        .BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .RD_LAT(FIX_RD), .WR_LAT(FIX_WR),
        .RAND_LAT(1'b0), .LAT_BITS(3), .LFSR_SEED(8'hA5)
    ) u_fix (
        .clk(clk), .rst(rst),
        .araddr(araddr[0]), .arvalid(arvalid[0]), .arready(arready[0]),
        .rdata(rdata[0]), .rresp(rresp[0]), .rvalid(rvalid[0]), .rready(rready[0]),
        .awaddr(awaddr[0]), .awvalid(awvalid[0]), .awready(awready[0]),
        .wdata(wdata[0]), .wstrb(wstrb[0]), .wvalid(wvalid[0]), .wready(wready[0]),
        .bresp(bresp[0]), .bvalid(bvalid[0]), .bready(bready[0])
    );

    ysyx_23060240_axi_sram #(
        .BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .RD_LAT(1), .WR_LAT(1),
        .RAND_LAT(1'b1), .LAT_BITS(3), .LFSR_SEED(8'hA5)
    ) u_rnd (
        .clk(clk), .rst(rst),
        .araddr(araddr[1]), .arvalid(arvalid[1]), .arready(arready[1]),
        .rdata(rdata[1]), .rresp(rresp[1]), .rvalid(rvalid[1]), .rready(rready[1]),
        .awaddr(awaddr[1]), .awvalid(awvalid[1]), .awready(awready[1]),
        .wdata(wdata[1]), .wstrb(wstrb[1]), .wvalid(wvalid[1]), .wready(wready[1]),
        .bresp(bresp[1]), .bvalid(bvalid[1]), .bready(bready[1])
    );

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [34:0] exp_r_q[$];   // {instance, rresp, rdata}
    logic [2:0]  exp_b_q[$];   // {instance, bresp}
    logic [31:0] model [int];  // key = instance*DEPTH + word index
    int r_rise [2];
    int b_rise [2];
    logic rv_prev [2];
    logic bv_prev [2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: no response within %0d cycles at t=%0t", name, TMO, $time);
    endtask

    function automatic bit in_win(input logic [31:0] a);
        logic [63:0] x;
        x = {32'h0, a};
        return (x >= 64'(BASE)) && (x < 64'(BASE) + 64'(4 * DEPTH));
    endfunction

    function automatic int key_of(input int k, input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return k * DEPTH + int'(off >> 2);
    endfunction

    function automatic logic [31:0] model_get(input int k, input logic [31:0] a);
        int key;
        key = key_of(k, a);
        return model.exists(key) ? model[key] : 32'h0;
    endfunction

    function automatic void expect_write(input int k, input logic [31:0] a,
                                         input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        exp_b_q.push_back({k[0], in_win(a) ? RESP_OKAY : RESP_DECERR});
        if (in_win(a)) begin
            w = model_get(k, a);
            for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
            model[key_of(k, a)] = w;
        end
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        logic [34:0] er;
        logic [2:0]  eb;
        for (int k = 0; k < 2; k++) begin
            if (rvalid[k] && !rv_prev[k]) r_rise[k] = cyc;
            if (bvalid[k] && !bv_prev[k]) b_rise[k] = cyc;
            rv_prev[k] = rvalid[k];
            bv_prev[k] = bvalid[k];
            if (!rst && rvalid[k] && rready[k]) begin
                if (exp_r_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL r_unexpected: inst %0d rdata %h with no pending read", k, rdata[k]);
                end else begin
                    er = exp_r_q.pop_front();
                    check("r_response", {k[0], rresp[k], rdata[k]}, er);
                end
            end
            if (!rst && bvalid[k] && bready[k]) begin
                if (exp_b_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL b_unexpected: inst %0d bresp %b with no pending write", k, bresp[k]);
                end else begin
                    eb = exp_b_q.pop_front();
                    check("b_response", {k[0], bresp[k]}, eb);
                end
            end
        end
    end

    // ---------------- driver tasks (enter and leave 1 time unit after posedge) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ar_send(input int k, input logic [31:0] a, output int hs);
        int n;
        n = 0;
        araddr[k] = a; arvalid[k] = 1'b1;
        @(negedge clk);
        while (!arready[k] && n < TMO) begin @(negedge clk); n++; end
        if (!arready[k]) timeout_fail("ar_handshake");
        hs = cyc + 1;
        tick();
        arvalid[k] = 1'b0; araddr[k] = $urandom;
    endtask

    task automatic aw_send(input int k, input logic [31:0] a, output int hs);
        int n;
        n = 0;
        awaddr[k] = a; awvalid[k] = 1'b1;
        @(negedge clk);
        while (!awready[k] && n < TMO) begin @(negedge clk); n++; end
        if (!awready[k]) timeout_fail("aw_handshake");
        hs = cyc + 1;
        tick();
        awvalid[k] = 1'b0; awaddr[k] = $urandom;
    endtask

    task automatic w_send(input int k, input logic [31:0] d, input logic [3:0] s, output int hs);
        int n;
        n = 0;
        wdata[k] = d; wstrb[k] = s; wvalid[k] = 1'b1;
        @(negedge clk);
        while (!wready[k] && n < TMO) begin @(negedge clk); n++; end
        if (!wready[k]) timeout_fail("w_handshake");
        hs = cyc + 1;
        tick();
        wvalid[k] = 1'b0; wdata[k] = $urandom; wstrb[k] = 4'($urandom);
    endtask

    task automatic wait_r(input int k, input int hold, input logic [33:0] e);
        int n;
        n = 0;
        rready[k] = 1'b0;
        @(negedge clk);
        while (!rvalid[k] && n < TMO) begin @(negedge clk); n++; end
        if (!rvalid[k]) begin
            timeout_fail("r_valid");
            tick();
            return;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("r_hold_stable", {rvalid[k], rresp[k], rdata[k]}, {1'b1, e});
        end
        tick();
        rready[k] = 1'b1;
        tick();
        rready[k] = 1'b0;
    endtask

    task automatic wait_b(input int k, input int hold, input logic [1:0] e);
        int n;
        n = 0;
        bready[k] = 1'b0;
        @(negedge clk);
        while (!bvalid[k] && n < TMO) begin @(negedge clk); n++; end
        if (!bvalid[k]) begin
            timeout_fail("b_valid");
            tick();
            return;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("b_hold_stable", {bvalid[k], bresp[k]}, {1'b1, e});
        end
        tick();
        bready[k] = 1'b1;
        tick();
        bready[k] = 1'b0;
    endtask

    task automatic do_read(input int k, input logic [31:0] a, input int hold, output int hs);
        logic [34:0] e;
        e = {k[0], in_win(a) ? RESP_OKAY : RESP_DECERR, in_win(a) ? model_get(k, a) : 32'h0};
        exp_r_q.push_back(e);
        ar_send(k, a, hs);
        wait_r(k, hold, e[33:0]);
    endtask

    task automatic do_write(input int k, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int ga, input int gw, input int hold,
                            output int ae, output int we);
        int ae_l, we_l;
        expect_write(k, a, d, s);
        fork
            begin repeat (ga) tick(); aw_send(k, a, ae_l); end
            begin repeat (gw) tick(); w_send(k, d, s, we_l); end
        join
        ae = ae_l;
        we = we_l;
        wait_b(k, hold, in_win(a) ? RESP_OKAY : RESP_DECERR);
    endtask

    task automatic check_idle(input int k);
        @(negedge clk);
        check("idle_outputs",
              {arready[k], awready[k], wready[k], rvalid[k], bvalid[k], rresp[k], bresp[k], rdata[k]},
              {3'b111, 2'b00, 2'b00, 2'b00, 32'h0});
        tick();
    endtask

    function automatic logic [31:0] rand_addr(input int lo, input int hi);
        if ($urandom_range(0, 9) == 0) begin
            return ($urandom_range(0, 1) == 0) ? 32'h7FFF_FFFC
                                               : BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 15));
        end
        return BASE + 32'(4 * $urandom_range(lo, hi)) + 32'($urandom_range(0, 3));
    endfunction

    // ---------------- stimulus ----------------
    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int hs, ae, we;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            araddr[k] = '0; arvalid[k] = 1'b0; rready[k] = 1'b0;
            awaddr[k] = '0; awvalid[k] = 1'b0; wdata[k] = '0; wstrb[k] = '0;
            wvalid[k] = 1'b0; bready[k] = 1'b0;
            r_rise[k] = 0; b_rise[k] = 0; rv_prev[k] = 1'b0; bv_prev[k] = 1'b0;
        end
        repeat (3) tick();
        rst = 1'b0;
        check_idle(0);
        check_idle(1);

        // Fixed-latency instance: basic write/read and latency
        do_write(0, BASE, 32'h0123_4567, 4'hF, 0, 0, 0, ae, we);
        do_write(0, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, ae, we);
        check("b_latency", 64'(b_rise[0]), 64'(ae + 1 + FIX_WR));
        do_read(0, BASE + 32'h10, 0, hs);
        check("r_latency", 64'(r_rise[0]), 64'(hs + 1 + FIX_RD));

        // Byte strobes: expected readback 0xFF22FF44
        do_write(0, BASE + 32'h20, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, ae, we);
        do_write(0, BASE + 32'h20, 32'h1122_3344, 4'b0101, 0, 0, 1, ae, we);
        check("strb_model", 64'(model_get(0, BASE + 32'h20)), 64'h0000_0000_FF22_FF44);
        do_read(0, BASE + 32'h20, 0, hs);

        // W three cycles before AW
        do_write(0, BASE + 32'h30, 32'h1111_2222, 4'hF, 0, 0, 0, ae, we);
        expect_write(0, BASE + 32'h30, 32'hCAFE_F00D, 4'hF);
        w_send(0, 32'hCAFE_F00D, 4'hF, we);
        @(negedge clk);
        check("w_first_readies", {awready[0], wready[0]}, 2'b10);
        tick();
        tick();
        aw_send(0, BASE + 32'h30, ae);
        wait_b(0, 0, RESP_OKAY);
        check("aw_after_w_gap", 64'(ae - we), 64'd3);
        check("b_latency_w_first", 64'(b_rise[0]), 64'(ae + 1 + FIX_WR));
        do_read(0, BASE + 32'h30, 0, hs);

        // Out-of-window accesses
        do_read(0, 32'h7FFF_FFFC, 0, hs);
        do_write(0, BASE + 32'h4000, 32'h5A5A_5A5A, 4'hF, 0, 0, 0, ae, we);
        do_read(0, BASE, 0, hs);

        // Reset in R_WAIT, then in W_WAIT
        ar_send(0, BASE + 32'h10, hs);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle(0);
        fork
            aw_send(0, BASE + 32'h10, ae);
            w_send(0, 32'h0BAD_F00D, 4'hF, we);
        join
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle(0);
        do_read(0, BASE + 32'h10, 0, hs);

        // Random-latency instance: preload, backpressure hold, random traffic
        for (int i = 0; i < 32; i++) do_write(1, BASE + 32'(4 * i), $urandom, 4'hF, 0, 0, 0, ae, we);
        do_read(1, BASE + 32'hC, 5, hs);

        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                do_read(1, rand_addr(0, 15), $urandom_range(0, 3), hs);
            end else begin
                do_write(1, rand_addr(0, 15), $urandom, 4'($urandom_range(0, 15)),
                         $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), ae, we);
            end
        end

        fork
            begin
                int h;
                for (int i = 0; i < 50; i++) do_read(1, rand_addr(0, 15), $urandom_range(0, 2), h);
            end
            begin
                int a2, w2;
                for (int i = 0; i < 50; i++)
                    do_write(1, rand_addr(16, 31), $urandom, 4'($urandom_range(0, 15)),
                             $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), a2, w2);
            end
        join
        for (int i = 16; i < 32; i++) do_read(1, BASE + 32'(4 * i), 0, hs);

        repeat (3) tick();
        check("r_queue_drained", 64'(exp_r_q.size()), 64'd0);
        check("b_queue_drained", 64'(exp_b_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
